r_top: RTL and testbench

Serial receive top for the UART link: the far-end counterpart of the 64-bit serial transmitter. It oversamples the `rxd` line at 8x baud, decodes 8N1/8E1/8O1 characters LSB first, checks parity and stop bits, and packs eight good bytes into one 64-bit word. A one-cycle `fr` strobe marks each completed word for the downstream consumer (BCI packet logic).

---
 rtl/r_top.sv | 204 ++++++++++++++++++++
 tb/tb_r_top.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_top.sv
// UART receive top: 8x oversampled 8N1/8E1/8O1 decoder that packs eight good
// bytes into a 64-bit word and pulses fr, or reports perr/ferr per dropped byte.
`timescale 1ns/1ps
module r_top #(
  parameter int unsigned CLK_DIV = 651
) (
  input  logic        clk,
  input  logic        rst_m,
  input  logic        parity_en,
  input  logic        parity_kind,
  input  logic        rxd,
  output logic [64:1] data,
  output logic        fr,
  output logic        perr,
  output logic        ferr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);

  function automatic logic f_par_mismatch(input logic [7:0] b, input logic pbit,
                                          input logic kind);
    f_par_mismatch = (^b) ^ pbit ^ kind;
  endfunction

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_rxd_p;
  logic [15:0] r_tick_cnt;
  logic [2:0]  r_sc;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_byte;
  logic        r_par_en;
  logic        r_par_kind;
  logic        r_par_err;
  logic [2:0]  r_bcnt;
  logic [63:0] r_asm;
  logic        w_rxd_s;
  logic        w_tick;
  logic        w_sc_clr;
  logic        w_go_data;
  logic        w_shift;
  logic        w_par_smp;
  logic        w_stop_smp;

  assign w_rxd_s = r_sync2;
  assign w_tick  = (r_tick_cnt == TICK_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_m) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode; every transition happens on a sample tick
  always_comb begin
    w_state_nx = r_state;
    w_sc_clr   = 1'b0;
    w_go_data  = 1'b0;
    w_shift    = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s && r_rxd_p) begin
            w_state_nx = S_START;
            w_sc_clr   = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_START: begin
          if (r_sc == 3'd3) begin
            if (!w_rxd_s) begin
              w_state_nx = S_DATA;
              w_go_data  = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_state_nx = S_START;
          end
        end
        S_DATA: begin
          if (r_sc == 3'd7) begin
            w_shift = 1'b1;
            if (r_bit_idx == 3'd7) begin
              w_state_nx = r_par_en ? S_PARITY : S_STOP;
            end else begin
              w_state_nx = S_DATA;
            end
          end else begin
            w_state_nx = S_DATA;
          end
        end
        S_PARITY: begin
          if (r_sc == 3'd7) begin
            w_par_smp  = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_state_nx = S_PARITY;
          end
        end
        S_STOP: begin
          if (r_sc == 3'd7) begin
            w_stop_smp = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_STOP;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Synchronizer, free-running tick counter and tick-rate edge history
  always_ff @(posedge clk) begin
    if (!rst_m) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxd_p    <= 1'b1;
      r_tick_cnt <= 16'd0;
      r_sc       <= 3'd0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_tick_cnt <= 16'd0;
        r_rxd_p    <= w_rxd_s;
        r_sc       <= (w_sc_clr || w_go_data) ? 3'd0 : r_sc + 3'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
    end
  end

  // Byte shift, parity check, word assembly and result pulses
  always_ff @(posedge clk) begin
    if (!rst_m) begin
      r_bit_idx  <= 3'd0;
      r_byte     <= 8'h00;
      r_par_en   <= 1'b0;
      r_par_kind <= 1'b0;
      r_par_err  <= 1'b0;
      r_bcnt     <= 3'd0;
      r_asm      <= 64'h0;
      data       <= 64'h0;
      fr         <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      fr   <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      if (w_go_data) begin
        r_par_en   <= parity_en;
        r_par_kind <= parity_kind;
        r_par_err  <= 1'b0;
        r_bit_idx  <= 3'd0;
      end
      if (w_shift) begin
        r_byte    <= {w_rxd_s, r_byte[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_par_smp) begin
        r_par_err <= f_par_mismatch(r_byte, w_rxd_s, r_par_kind);
      end
      // Framing error outranks parity error; either drops the partial word
      if (w_stop_smp) begin
        if (!w_rxd_s) begin
          ferr   <= 1'b1;
          r_bcnt <= 3'd0;
        end else if (r_par_err) begin
          perr   <= 1'b1;
          r_bcnt <= 3'd0;
        end else begin
          r_asm[{r_bcnt, 3'b000} +: 8] <= r_byte;
          r_bcnt <= r_bcnt + 3'd1;
          if (r_bcnt == 3'd7) begin
            data <= {r_byte, r_asm[55:0]};
            fr   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_r_top.sv
// Directed self-checking bench for r_top at CLK_DIV=4 (32 clk per bit).
`timescale 1ns/1ps
module tb_r_top;
  localparam real BIT_NS  = 320.0;
  localparam real FAST_NS = 320.0 / 1.02;

  logic        clk = 1'b0;
  logic        rst_m = 1'b0;
  logic        parity_en = 1'b0;
  logic        parity_kind = 1'b0;
  logic        rxd = 1'b1;
  logic [64:1] data;
  logic        fr;
  logic        perr;
  logic        ferr;

  int n_tests = 0;
  int n_fail = 0;
  int n_fr = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_excl = 0;
  int n_wide = 0;
  logic p_fr = 1'b0;
  logic p_perr = 1'b0;
  logic p_ferr = 1'b0;
  logic [63:0] words[$];

  r_top #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_m(rst_m), .parity_en(parity_en), .parity_kind(parity_kind),
    .rxd(rxd), .data(data), .fr(fr), .perr(perr), .ferr(ferr)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (fr) begin
      n_fr++;
      words.push_back(data);
    end
    if (perr) n_perr++;
    if (ferr) n_ferr++;
    if ((int'(fr) + int'(perr) + int'(ferr)) > 1) n_excl++;
    if ((fr && p_fr) || (perr && p_perr) || (ferr && p_ferr)) n_wide++;
    p_fr = fr;
    p_perr = perr;
    p_ferr = ferr;
  end

  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par,
                            input logic stop, input real bit_ns, input int idle_bits);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    if (has_par) begin
      rxd = par;
      #(bit_ns);
    end
    rxd = stop;
    #(bit_ns);
    rxd = 1'b1;
    #(bit_ns * idle_bits);
  endtask

  task automatic test_reset();
    rxd = 1'b1;
    rst_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (data !== 64'h0 || fr !== 1'b0 || perr !== 1'b0 || ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: data=%h fr=%b perr=%b ferr=%b, want 0/0/0/0", data, fr, perr, ferr);
    end
    rst_m = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_word();
    logic [7:0] v [8];
    int f0, p0, e0, w0;
    logic [63:0] got;
    v = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    parity_en = 1'b0;
    f0 = n_fr; p0 = n_perr; e0 = n_ferr; w0 = words.size();
    for (int i = 0; i < 7; i++) send_frame(v[i], 1'b0, 1'b0, 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_fr !== f0) begin
      n_fail++;
      $display("FAIL word_early_fr: fr count %0d, want %0d", n_fr - f0, 0);
    end
    send_frame(v[7], 1'b0, 1'b0, 1'b1, BIT_NS, 1);
    got = (words.size() > w0) ? words[w0] : 64'hx;
    n_tests++;
    if (n_fr !== f0 + 1 || got !== 64'hEFCDAB8967452301) begin
      n_fail++;
      $display("FAIL word_data: fr=%0d data=%h, want 1 EFCDAB8967452301", n_fr - f0, got);
    end
    n_tests++;
    if (n_perr !== p0 || n_ferr !== e0) begin
      n_fail++;
      $display("FAIL word_errs: perr=%0d ferr=%0d, want 0 0", n_perr - p0, n_ferr - e0);
    end
  endtask

  task automatic test_parity_even();
    logic [7:0] v [8];
    int f0, p0, e0, w0;
    logic [63:0] got;
    v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    parity_en = 1'b1;
    parity_kind = 1'b0;
    f0 = n_fr; p0 = n_perr; e0 = n_ferr; w0 = words.size();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_perr !== p0 || n_ferr !== e0) begin
      n_fail++;
      $display("FAIL even_good: perr=%0d ferr=%0d, want 0 0", n_perr - p0, n_ferr - e0);
    end
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_perr !== p0 + 1 || n_ferr !== e0) begin
      n_fail++;
      $display("FAIL even_bad: perr=%0d ferr=%0d, want 1 0", n_perr - p0, n_ferr - e0);
    end
    // Parity of 11,22,...,88 is even for all but none; compute the bit per byte
    for (int i = 0; i < 7; i++) send_frame(v[i], 1'b1, ^v[i], 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_fr !== f0) begin
      n_fail++;
      $display("FAIL even_bcnt_cleared: fr count %0d after 7 bytes, want 0", n_fr - f0);
    end
    send_frame(v[7], 1'b1, ^v[7], 1'b1, BIT_NS, 1);
    got = (words.size() > w0) ? words[w0] : 64'hx;
    n_tests++;
    if (n_fr !== f0 + 1 || got !== 64'h8877665544332211) begin
      n_fail++;
      $display("FAIL even_word: fr=%0d data=%h, want 1 8877665544332211", n_fr - f0, got);
    end
  endtask

  task automatic test_parity_odd_ferr();
    int p0, e0, f0;
    parity_en = 1'b1;
    parity_kind = 1'b1;
    p0 = n_perr; e0 = n_ferr; f0 = n_fr;
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_perr !== p0 || n_ferr !== e0) begin
      n_fail++;
      $display("FAIL odd_good: perr=%0d ferr=%0d, want 0 0", n_perr - p0, n_ferr - e0);
    end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, BIT_NS, 2);
    n_tests++;
    if (n_ferr !== e0 + 1 || n_perr !== p0 || n_fr !== f0) begin
      n_fail++;
      $display("FAIL both_errs: ferr=%0d perr=%0d fr=%0d, want 1 0 0", n_ferr - e0, n_perr - p0, n_fr - f0);
    end
  endtask

  task automatic test_glitch_and_low();
    int p0, e0, f0;
    parity_en = 1'b0;
    p0 = n_perr; e0 = n_ferr; f0 = n_fr;
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    rxd = 1'b1;
    repeat (400) @(posedge clk);
    n_tests++;
    if (n_perr !== p0 || n_ferr !== e0 || n_fr !== f0) begin
      n_fail++;
      $display("FAIL glitch: fr=%0d perr=%0d ferr=%0d, want 0 0 0", n_fr - f0, n_perr - p0, n_ferr - e0);
    end
    rxd = 1'b0;
    repeat (500) @(posedge clk);
    rxd = 1'b1;
    repeat (400) @(posedge clk);
    n_tests++;
    if (n_ferr !== e0 + 1 || n_perr !== p0 || n_fr !== f0) begin
      n_fail++;
      $display("FAIL line_low: ferr=%0d perr=%0d fr=%0d, want 1 0 0", n_ferr - e0, n_perr - p0, n_fr - f0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v [8];
    int f0, w0, e0, p0;
    logic [63:0] got;
    v = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    parity_en = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b0, 1'b0, 1'b1, BIT_NS, 1);
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;
    #(BIT_NS * 2.5);
    @(posedge clk);
    #1 rst_m = 1'b0;
    @(posedge clk);
    #1 rst_m = 1'b1;
    @(negedge clk);
    n_tests++;
    if (data !== 64'h0) begin
      n_fail++;
      $display("FAIL midframe_reset_data: data=%h, want 0", data);
    end
    #(BIT_NS * 8);
    f0 = n_fr; w0 = words.size(); e0 = n_ferr; p0 = n_perr;
    for (int i = 0; i < 7; i++) send_frame(v[i], 1'b0, 1'b0, 1'b1, BIT_NS, 1);
    n_tests++;
    if (n_fr !== f0) begin
      n_fail++;
      $display("FAIL midframe_early_fr: fr count %0d after 7 bytes, want 0", n_fr - f0);
    end
    send_frame(v[7], 1'b0, 1'b0, 1'b1, BIT_NS, 1);
    got = (words.size() > w0) ? words[w0] : 64'hx;
    n_tests++;
    if (n_fr !== f0 + 1 || got !== 64'h1807F6E5D4C3B2A1 || n_ferr !== e0 || n_perr !== p0) begin
      n_fail++;
      $display("FAIL midframe_word: fr=%0d data=%h errs=%0d, want 1 1807F6E5D4C3B2A1 0",
               n_fr - f0, got, (n_ferr - e0) + (n_perr - p0));
    end
  endtask

  task automatic test_back_to_back();
    int f0, w0, e0, p0;
    logic [63:0] got0, got1;
    parity_en = 1'b0;
    f0 = n_fr; w0 = words.size(); e0 = n_ferr; p0 = n_perr;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, FAST_NS, 0);
    for (int i = 1; i <= 8; i++) send_frame(8'(i * 16), 1'b0, 1'b0, 1'b1, FAST_NS, 0);
    #(BIT_NS * 3);
    got0 = (words.size() > w0) ? words[w0] : 64'hx;
    got1 = (words.size() > w0 + 1) ? words[w0 + 1] : 64'hx;
    n_tests++;
    if (n_fr !== f0 + 2 || n_ferr !== e0 || n_perr !== p0) begin
      n_fail++;
      $display("FAIL b2b_count: fr=%0d errs=%0d, want 2 0", n_fr - f0, (n_ferr - e0) + (n_perr - p0));
    end
    n_tests++;
    if (got0 !== 64'h0807060504030201) begin
      n_fail++;
      $display("FAIL b2b_word0: data=%h, want 0807060504030201", got0);
    end
    n_tests++;
    if (got1 !== 64'h8070605040302010) begin
      n_fail++;
      $display("FAIL b2b_word1: data=%h, want 8070605040302010", got1);
    end
  endtask

  task automatic test_pulse_shape();
    n_tests++;
    if (n_excl !== 0 || n_wide !== 0) begin
      n_fail++;
      $display("FAIL pulse_shape: overlap=%0d wide=%0d, want 0 0", n_excl, n_wide);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_parity_even();
    test_parity_odd_ferr();
    test_glitch_and_low();
    test_reset_midframe();
    test_back_to_back();
    test_pulse_shape();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
